ifetch_prefetch: RTL and testbench

- Instruction-fetch front end for the RV64 single-cycle core.
- Owns the architectural fetch PC and issues word requests to a variable-latency instruction memory port.
- Buffers returned instructions, paired with their PCs, in a small in-order prefetch queue.
- Presents {pc, instr} to the execute stage over a valid/ready handshake; JALR/trap redirects from execute flush the queue and restart fetch.

---
 rtl/ifetch_pkg.sv | 19 +
 rtl/ifetch_queue.sv | 86 ++++++++
 rtl/ifetch_prefetch.sv | 137 +++++++++++++
 tb/tb_ifetch_prefetch.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2,
        FAULT = 2'd3
    } state_t;

    typedef struct packed {
        logic        filled;
        logic [63:0] pc;
        logic [31:0] instr;
    } entry_t;

    localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/ifetch_queue.sv
// In-order prefetch buffer: slots are allocated at request time, filled in
// response order and popped from the head; flush empties everything.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH),
    parameter int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             alloc_i,
    input  logic [63:0]      alloc_pc_i,
    input  logic             fill_i,
    input  logic [31:0]      fill_instr_i,
    input  logic             pop_i,
    output entry_t           head_o,
    output logic [CNT_W-1:0] count_next_o
);

    entry_t             slots_q [DEPTH];
    entry_t             slots_d [DEPTH];
    logic [PTR_W-1:0]   alloc_ptr_q, alloc_ptr_d;
    logic [PTR_W-1:0]   fill_ptr_q, fill_ptr_d;
    logic [PTR_W-1:0]   head_ptr_q, head_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    always_comb begin
        slots_d     = slots_q;
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        head_ptr_d  = head_ptr_q;
        count_d     = count_q;
        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_d[i] = '0;
            end
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            head_ptr_d  = '0;
            count_d     = '0;
        end else begin
            // A popped slot is cleared so a stale filled bit never reappears
            // when the head pointer wraps onto it.
            if (pop_i) begin
                slots_d[head_ptr_q] = '0;
                head_ptr_d          = head_ptr_q + PTR_W'(1);
            end
            if (alloc_i) begin
                slots_d[alloc_ptr_q] = '{filled: 1'b0, pc: alloc_pc_i, instr: 32'h0};
                alloc_ptr_d          = alloc_ptr_q + PTR_W'(1);
            end
            if (fill_i) begin
                slots_d[fill_ptr_q].filled = 1'b1;
                slots_d[fill_ptr_q].instr  = fill_instr_i;
                fill_ptr_d                 = fill_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(alloc_i) - CNT_W'(pop_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= '0;
            end
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            head_ptr_q  <= '0;
            count_q     <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= slots_d[i];
            end
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            head_ptr_q  <= head_ptr_d;
            count_q     <= count_d;
        end
    end

    assign head_o       = slots_q[head_ptr_q];
    assign count_next_o = count_d;

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction-fetch front end: fetch PC, request credits and redirect handling.
// Optional misaligned-redirect fault is enabled with IFETCH_MISALIGN_FAULT_EN.
module ifetch_prefetch
    import ifetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
    parameter int unsigned PTR_W    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_instr,
    output logic        fetch_fault
);

    localparam int unsigned      CNT_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_t           state_q, state_d;
    logic [63:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] q_count_next;
    logic [CNT_W-1:0] occ_d;
    entry_t           head;
    logic             issue, alloc, rsp_ok, rsp_fill, rsp_drop, pop;
    logic             redir_bad;
    logic [63:0]      redir_tgt;
    logic             unused_redir_lsb;

    assign redir_tgt        = {redirect_pc[63:2], 2'b00};
    assign unused_redir_lsb = ^redirect_pc[1:0];

`ifdef IFETCH_MISALIGN_FAULT_EN
    assign redir_bad   = redirect_valid & redirect_pc[1];
    assign fetch_fault = (state_q == FAULT);
`else
    assign redir_bad   = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    assign issue    = imem_req & imem_gnt;
    assign rsp_ok   = imem_rvalid & (inflight_q != '0);
    assign rsp_drop = rsp_ok & (drop_cnt_q != '0);
    // A redirect flushes the queue, so nothing from this cycle may land in it.
    assign alloc    = issue & ~redirect_valid;
    assign rsp_fill = rsp_ok & (drop_cnt_q == '0) & ~redirect_valid;
    assign pop      = head.filled & out_ready & ~redirect_valid;

    assign inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(rsp_ok);
    assign drop_cnt_d = redirect_valid ? inflight_d : (drop_cnt_q - CNT_W'(rsp_drop));
    // Credits: allocated slots plus responses still owed to the drop counter.
    assign occ_d      = q_count_next + drop_cnt_d;

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            IDLE:        state_d = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                state_d  = (occ_d >= DEPTH_C) ? FULL : FETCH;
            end
            FULL:        state_d = (occ_d >= DEPTH_C) ? FULL : FETCH;
            FAULT:       state_d = FAULT;
            default:     state_d = IDLE;
        endcase
        if (redirect_valid) begin
            if (redir_bad) begin
                state_d = FAULT;
            end else begin
                state_d = (occ_d >= DEPTH_C) ? FULL : FETCH;
            end
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            if (!redir_bad) begin
                fetch_pc_d = redir_tgt;
            end
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + 64'(INSTR_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    ifetch_queue #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_queue (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (redirect_valid),
        .alloc_i      (alloc),
        .alloc_pc_i   (fetch_pc_q),
        .fill_i       (rsp_fill),
        .fill_instr_i (imem_rdata),
        .pop_i        (pop),
        .head_o       (head),
        .count_next_o (q_count_next)
    );

    assign imem_addr = fetch_pc_q;
    assign out_valid = head.filled;
    assign out_pc    = head.pc;
    assign out_instr = head.instr;

    // A response with nothing outstanding is a memory protocol error.
    rsp_without_req_a: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> (inflight_q != '0));

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Bench for ifetch_prefetch: scripted memory model plus an output scoreboard.
`timescale 1ns/1ps
module tb_ifetch_prefetch;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        fetch_fault;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int grant_cnt = 0;
  int grant_limit = 0;
  int mem_lat = 1;
  logic [63:0] exp_q[$];
  logic [63:0] pend_addr[$];
  int          pend_due[$];
  logic [63:0] gaddr_q[$];

  ifetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .fetch_fault(fetch_fault)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {a[17:2], a[17:2]} ^ 32'hA5C3_0F1E ^ a[63:32];
  endfunction

  // memory responder and output scoreboard, acting on the falling edge
  task automatic bus_proc();
    logic [63:0] exp_pc;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_addr.delete(); pend_due.delete(); gaddr_q.delete();
        grant_cnt = 0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      end else begin
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
          imem_rvalid = 1'b1;
          imem_rdata = mem_word(pend_addr[0]);
          void'(pend_addr.pop_front());
          void'(pend_due.pop_front());
        end else begin
          imem_rvalid = 1'b0;
          imem_rdata = '0;
        end
        imem_gnt = (grant_cnt < grant_limit);
        if (imem_req && imem_gnt) begin
          pend_addr.push_back(imem_addr);
          pend_due.push_back(cyc + mem_lat);
          gaddr_q.push_back(imem_addr);
          grant_cnt++;
        end
        if (out_valid && out_ready && !redirect_valid) begin
          tests_run++;
          if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL out_unexpected: got pc %0h, required no output", out_pc);
          end else begin
            exp_pc = exp_q.pop_front();
            if (out_pc !== exp_pc || out_instr !== mem_word(exp_pc)) begin
              tests_failed++;
              $display("FAIL out_data: got pc %0h instr %0h, required pc %0h instr %0h",
                       out_pc, out_instr, exp_pc, mem_word(exp_pc));
            end
          end
        end
      end
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    grant_limit = 0; mem_lat = 1; exp_q.delete();
    step(2);
    rst = 1'b0;
  endtask

  task automatic redirect(input logic [63:0] pc);
    redirect_valid = 1'b1; redirect_pc = pc;
    step(1);
    redirect_valid = 1'b0;
  endtask

  task automatic drain(input int bound, output int cycles);
    cycles = 0;
    while (exp_q.size() > 0 && cycles < bound) begin
      step(1);
      cycles++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; grant_limit = 0;
    step(1);
    tests_run += 6;
    if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL rst_req: got %0b required 0", imem_req); end
    if (imem_addr !== 64'h0) begin tests_failed++; $display("FAIL rst_addr: got %0h required 0", imem_addr); end
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %0b required 0", out_valid); end
    if (out_pc !== 64'h0) begin tests_failed++; $display("FAIL rst_pc: got %0h required 0", out_pc); end
    if (out_instr !== 32'h0) begin tests_failed++; $display("FAIL rst_instr: got %0h required 0", out_instr); end
    if (fetch_fault !== 1'b0) begin tests_failed++; $display("FAIL rst_fault: got %0b required 0", fetch_fault); end
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_stream();
    int n;
    do_reset();
    out_ready = 1'b1; grant_limit = 1000; mem_lat = 1;
    for (int i = 0; i < 12; i++) exp_q.push_back(64'(i) * 64'd4);
    step(1);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_lat1: got %0b required 0", out_valid); end
    step(1);
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL stream_lat2: got %0b required 0", out_valid); end
    step(1);
    tests_run++;
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL stream_lat3: got %0b required 1", out_valid); end
    drain(40, n);
    tests_run += 2;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL stream_drain: got %0d left required 0", exp_q.size()); end
    if (n != 12) begin tests_failed++; $display("FAIL stream_rate: got %0d cycles required 12", n); end
  endtask

  task automatic test_full();
    logic [63:0] a;
    do_reset();
    grant_limit = 1000;
    step(10);
    tests_run += 2;
    if (grant_cnt != DEPTH) begin tests_failed++; $display("FAIL full_grants: got %0d required %0d", grant_cnt, DEPTH); end
    if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL full_req: got %0b required 0", imem_req); end
    for (int i = 0; i < DEPTH; i++) begin
      a = (gaddr_q.size() > i) ? gaddr_q[i] : 64'hx;
      tests_run++;
      if (a !== 64'(i) * 64'd4) begin tests_failed++; $display("FAIL full_addr%0d: got %0h required %0h", i, a, 64'(i) * 64'd4); end
    end
    exp_q.push_back(64'h0);
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    step(3);
    a = (gaddr_q.size() > 4) ? gaddr_q[4] : 64'hx;
    tests_run += 4;
    if (grant_cnt != DEPTH + 1) begin tests_failed++; $display("FAIL refill_grants: got %0d required %0d", grant_cnt, DEPTH + 1); end
    if (a !== 64'h10) begin tests_failed++; $display("FAIL refill_addr: got %0h required 10", a); end
    if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL refill_req: got %0b required 0", imem_req); end
    if (out_valid !== 1'b1 || out_pc !== 64'h4) begin tests_failed++; $display("FAIL refill_head: got %0b/%0h required 1/4", out_valid, out_pc); end
  endtask

  task automatic test_redirect_drop();
    int n;
    do_reset();
    mem_lat = 4; grant_limit = 2;
    n = 0;
    while (grant_cnt < 2 && n < 20) begin step(1); n++; end
    tests_run++;
    if (grant_cnt != 2) begin tests_failed++; $display("FAIL drop_setup: got %0d grants required 2", grant_cnt); end
    grant_limit = 1000;
    redirect(64'h100);
    tests_run += 2;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL drop_valid: got %0b required 0", out_valid); end
    if (imem_addr !== 64'h100) begin tests_failed++; $display("FAIL drop_addr: got %0h required 100", imem_addr); end
    exp_q.delete();
    exp_q.push_back(64'h100); exp_q.push_back(64'h104); exp_q.push_back(64'h108);
    out_ready = 1'b1;
    drain(80, n);
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL drop_drain: got %0d left required 0", exp_q.size()); end
  endtask

  task automatic test_gnt_stall();
    int n;
    logic [63:0] a;
    do_reset();
    step(1);
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
        tests_failed++; $display("FAIL stall_hold%0d: got %0b/%0h required 1/0", i, imem_req, imem_addr);
      end
      step(1);
    end
    redirect(64'h200);
    tests_run++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h200) begin
      tests_failed++; $display("FAIL stall_redir: got %0b/%0h required 1/200", imem_req, imem_addr);
    end
    grant_limit = 3;
    exp_q.push_back(64'h200); exp_q.push_back(64'h204); exp_q.push_back(64'h208);
    out_ready = 1'b1;
    drain(40, n);
    a = (gaddr_q.size() > 0) ? gaddr_q[0] : 64'hx;
    tests_run += 2;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL stall_drain: got %0d left required 0", exp_q.size()); end
    if (a !== 64'h200) begin tests_failed++; $display("FAIL stall_first: got %0h required 200", a); end
  endtask

  task automatic test_wrap();
    int n;
    logic [63:0] a;
    do_reset();
    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    grant_limit = 2;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC); exp_q.push_back(64'h0);
    out_ready = 1'b1;
    drain(40, n);
    a = (gaddr_q.size() > 1) ? gaddr_q[1] : 64'hx;
    tests_run += 3;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL wrap_drain: got %0d left required 0", exp_q.size()); end
    if (a !== 64'h0) begin tests_failed++; $display("FAIL wrap_addr: got %0h required 0", a); end
    if (fetch_fault !== 1'b0) begin tests_failed++; $display("FAIL wrap_fault: got %0b required 0", fetch_fault); end
  endtask

  task automatic test_misalign();
    int n;
    int base;
    logic [63:0] a;
    do_reset();
    grant_limit = 1000;
    step(8);
    base = gaddr_q.size();
    redirect(64'h102);
`ifdef IFETCH_MISALIGN_FAULT_EN
    tests_run++;
    if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL fault_enter: got %0b/%0b/%0b required 1/0/0", fetch_fault, imem_req, out_valid);
    end
    step(3);
    tests_run++;
    if (fetch_fault !== 1'b1 || imem_req !== 1'b0) begin
      tests_failed++; $display("FAIL fault_hold: got %0b/%0b required 1/0", fetch_fault, imem_req);
    end
    base = gaddr_q.size();
    redirect(64'h104);
    tests_run++;
    if (fetch_fault !== 1'b0) begin tests_failed++; $display("FAIL fault_clear: got %0b required 0", fetch_fault); end
    exp_q.push_back(64'h104); exp_q.push_back(64'h108);
    out_ready = 1'b1;
    drain(40, n);
    a = (gaddr_q.size() > base) ? gaddr_q[base] : 64'hx;
    tests_run += 2;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL fault_drain: got %0d left required 0", exp_q.size()); end
    if (a !== 64'h104) begin tests_failed++; $display("FAIL fault_addr: got %0h required 104", a); end
`else
    tests_run++;
    if (fetch_fault !== 1'b0) begin tests_failed++; $display("FAIL misalign_fault: got %0b required 0", fetch_fault); end
    exp_q.push_back(64'h100); exp_q.push_back(64'h104);
    out_ready = 1'b1;
    drain(40, n);
    a = (gaddr_q.size() > base) ? gaddr_q[base] : 64'hx;
    tests_run += 2;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL misalign_drain: got %0d left required 0", exp_q.size()); end
    if (a !== 64'h100) begin tests_failed++; $display("FAIL misalign_addr: got %0h required 100", a); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    fork
      bus_proc();
    join_none
    test_reset();
    test_stream();
    test_full();
    test_redirect_drop();
    test_gnt_stall();
    test_wrap();
    test_misalign();
    grant_limit = 1000;
    step(3);
    test_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
